// File: rtl/usb_fifo_tx.sv
// Write side of a 245-style synchronous USB FIFO: claims the shared bus via req/gnt,
// inserts a turnaround cycle, then bursts stream words to the chip under usb_tx_full.
module usb_fifo_tx #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 64,
  parameter int COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   s_data,
  input  logic [3:0]         s_be,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               bus_req,
  input  logic               bus_gnt,
  input  logic               usb_tx_full,
  output logic               usb_wren_l,
  output logic [WIDTH-1:0]   usb_data_o,
  output logic [3:0]         usb_be_o,
  output logic               usb_data_oe,
  output logic [COUNT_W-1:0] words_sent
);

  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_TURN,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic               wren_l_q, wren_l_d;
  logic               oe_q, oe_d;
  logic               req_q, req_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [3:0]         be_q, be_d;
  logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [COUNT_W-1:0] words_q, words_d;
  logic               accept;
  logic               room_in_burst;

  assign accept        = (state_q == ST_WRITE) && !usb_tx_full;
  assign room_in_burst = burst_cnt_q < BURST_LAST;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    be_d        = be_q;
    burst_cnt_d = burst_cnt_q;
    words_d     = words_q;
    s_ready     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus_gnt) state_d = ST_TURN;
      end
      ST_TURN: begin
        s_ready     = 1'b1;
        data_d      = s_data;
        be_d        = s_be;
        burst_cnt_d = '0;
        state_d     = ST_WRITE;
      end
      ST_WRITE: begin
        // While full the current word simply stays on the bus with the strobe low.
        if (accept) begin
          words_d     = words_q + COUNT_W'(1);
          burst_cnt_d = burst_cnt_q + BC_W'(1);
          s_ready     = room_in_burst;
          if (s_valid && room_in_burst) begin
            data_d = s_data;
            be_d   = s_be;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus-facing outputs are registered, so derive them from the state being entered.
    req_d    = (state_d != ST_IDLE);
    oe_d     = (state_d == ST_TURN) || (state_d == ST_WRITE);
    wren_l_d = (state_d != ST_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wren_l_q    <= 1'b1;
      oe_q        <= 1'b0;
      req_q       <= 1'b0;
      data_q      <= '0;
      be_q        <= '0;
      burst_cnt_q <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      wren_l_q    <= wren_l_d;
      oe_q        <= oe_d;
      req_q       <= req_d;
      data_q      <= data_d;
      be_q        <= be_d;
      burst_cnt_q <= burst_cnt_d;
      words_q     <= words_d;
    end
  end

  assign bus_req     = req_q;
  assign usb_wren_l  = wren_l_q;
  assign usb_data_oe = oe_q;
  assign usb_data_o  = data_q;
  assign usb_be_o    = be_q;
  assign words_sent  = words_q;

endmodule

// File: tb/tb_usb_fifo_tx.sv
// Bench for usb_fifo_tx: stream driver, simple arbiter and chip model, with a word
// scoreboard and per-cycle bus-protocol checks plus a few hand-computed timelines.
module tb_usb_fifo_tx;

  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 64;
  localparam int COUNT_W   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [WIDTH-1:0]   s_data = '0;
  logic [3:0]         s_be = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic               bus_req;
  logic               bus_gnt = 1'b0;
  logic               usb_tx_full = 1'b0;
  logic               usb_wren_l;
  logic [WIDTH-1:0]   usb_data_o;
  logic [3:0]         usb_be_o;
  logic               usb_data_oe;
  logic [COUNT_W-1:0] words_sent;

  usb_fifo_tx #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_be(s_be), .s_valid(s_valid), .s_ready(s_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .usb_tx_full(usb_tx_full), .usb_wren_l(usb_wren_l),
    .usb_data_o(usb_data_o), .usb_be_o(usb_be_o), .usb_data_oe(usb_data_oe),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment: arbiter grants after a delay and only withdraws once bus_req is low.
  logic gnt_tie    = 1'b1;
  int   gnt_fixed  = 0;
  int   gnt_wait   = 0;
  logic full_rand  = 1'b0;
  logic full_force = 1'b0;

  always @(negedge clk) begin
    if (gnt_tie) bus_gnt = 1'b1;
    else if (!bus_req) begin
      bus_gnt  = 1'b0;
      gnt_wait = (gnt_fixed >= 0) ? gnt_fixed : int'($urandom_range(0, 4));
    end else if (gnt_wait > 0) gnt_wait--;
    else bus_gnt = 1'b1;
  end

  always @(negedge clk) usb_tx_full = full_rand ? ($urandom_range(0, 99) < 30) : full_force;

  // Reference model: words enter a FIFO on handshake and must leave it, in order, on acceptance.
  logic [35:0] exp_q[$];
  int unsigned model_cnt = 0;
  int          burst_acc = 0;
  int          bursts_q[$];
  int          held_cycles = 0;
  int          nogrant_cycles = 0;
  int          g_rise = -1;
  logic        prev_oe = 1'b0, prev_wren = 1'b1, prev_req = 1'b0, prev_gnt = 1'b0;
  logic        prev_held = 1'b0, rel_pending = 1'b0;
  logic [35:0] prev_word = '0;
  logic [35:0] head;

  always @(negedge clk) begin
    #3;
    cyc++;
    if (rst) begin
      exp_q.delete();
      model_cnt   = 0;
      burst_acc   = 0;
      prev_oe     = 1'b0;
      prev_wren   = 1'b1;
      prev_req    = 1'b0;
      prev_held   = 1'b0;
      rel_pending = 1'b0;
      g_rise      = -1;
    end else begin
      chk("words_sent", 64'(words_sent), 64'(model_cnt));
      if (!usb_wren_l) chk("wren_implies_oe", 64'(usb_data_oe), 64'(1));
      if (usb_data_oe) chk("oe_implies_req", 64'(bus_req), 64'(1));
      if (bus_req && !bus_gnt) begin
        nogrant_cycles++;
        chk("quiet_before_gnt", 64'({usb_data_oe, usb_wren_l}), 64'(1));
      end
      if (prev_gnt && bus_req) chk("gnt_held_while_req", 64'(bus_gnt), 64'(1));
      if (s_ready) chk("ready_only_when_driving", 64'(usb_data_oe), 64'(1));
      if (usb_data_oe && usb_wren_l) begin
        chk("turn_ready", 64'(s_ready), 64'(1));
        chk("turn_only_at_oe_rise", 64'(!prev_oe), 64'(1));
      end
      if (!usb_wren_l && usb_tx_full) begin
        held_cycles++;
        chk("ready_low_when_full", 64'(s_ready), 64'(0));
      end
      if (prev_held) begin
        chk("held_wren", 64'(usb_wren_l), 64'(0));
        chk("held_word", 64'({usb_be_o, usb_data_o}), 64'(prev_word));
      end
      if (!prev_oe && usb_data_oe) begin
        chk("turn_wren_high", 64'(usb_wren_l), 64'(1));
        chk("turn_after_gnt", 64'(prev_req && prev_gnt), 64'(1));
        burst_acc = 0;
      end
      if (prev_oe && !usb_data_oe) begin
        chk("release_req", 64'(bus_req), 64'(1));
        chk("burst_within_max", 64'(burst_acc <= MAX_BURST), 64'(1));
        bursts_q.push_back(burst_acc);
        rel_pending = 1'b1;
      end else if (rel_pending) begin
        chk("idle_after_release", 64'(bus_req), 64'(0));
        rel_pending = 1'b0;
      end
      if (bus_req && bus_gnt && !prev_gnt) g_rise = cyc;
      if (prev_wren && !usb_wren_l) begin
        if (g_rise >= 0) chk("gnt_to_write", 64'(cyc - g_rise), 64'(2));
        g_rise = -1;
      end
      if (!usb_wren_l && !usb_tx_full) begin
        chk("accept_has_word", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          chk("accepted_word", 64'({usb_be_o, usb_data_o}), 64'(head));
        end
        $display("tx %0d: data=%08h be=%h", model_cnt, usb_data_o, usb_be_o);
        model_cnt++;
        burst_acc++;
      end
      if (s_valid && s_ready) exp_q.push_back({s_be, s_data});
      prev_oe   = usb_data_oe;
      prev_wren = usb_wren_l;
      prev_req  = bus_req;
      prev_held = !usb_wren_l && usb_tx_full;
      prev_word = {usb_be_o, usb_data_o};
    end
    prev_gnt = bus_gnt;
  end

  // Stimulus tasks all start and end on a falling edge.
  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // mode 0: data = index; mode 1: random data; mode 2: random data and random gaps.
  task automatic send(input int n, input int mode, input int starve_idx, input int starve_len);
    int  gap;
    bit  ok;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = (mode == 0) ? 32'(i) : $urandom;
      s_be    = (mode == 0) ? 4'hF : 4'($urandom_range(0, 15));
      ok = 1'b0;
      for (int w = 0; w < 3000; w++) begin
        #3;
        if (s_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_handshake: word %0d s_ready=0 after budget, required 1", i);
        @(negedge clk);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
      gap = 0;
      if (mode == 2 && $urandom_range(0, 4) == 0) gap = int'($urandom_range(1, 3));
      if (i == starve_idx) gap = starve_len;
      if (gap > 0) begin
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 500; w++) begin
      #3;
      if (exp_q.size() == 0 && !bus_req) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("drain_complete", 64'(done), 64'(1));
    @(negedge clk);
  endtask

  task automatic single_word();
    logic [5:0]  exp_wren;
    logic [5:0]  exp_oe;
    logic [5:0]  exp_req;
    int unsigned start;
    exp_wren = 6'b110111;
    exp_oe   = 6'b001100;
    exp_req  = 6'b011110;
    start    = model_cnt;
    s_valid  = 1'b1;
    s_data   = 32'hDEADBEEF;
    s_be     = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #3;
      chk($sformatf("single_wren_c%0d", k), 64'(usb_wren_l), 64'(exp_wren[k]));
      chk($sformatf("single_oe_c%0d", k), 64'(usb_data_oe), 64'(exp_oe[k]));
      chk($sformatf("single_req_c%0d", k), 64'(bus_req), 64'(exp_req[k]));
      if (k == 2) chk("single_ready_c2", 64'(s_ready), 64'(1));
      if (k == 3) chk("single_data_c3", 64'(usb_data_o), 64'h0000_0000_DEAD_BEEF);
      @(negedge clk);
      if (k == 2) s_valid = 1'b0;
    end
    #3;
    chk("single_count", 64'(words_sent), 64'(start + 1));
    @(negedge clk);
  endtask

  int          exp_b[3];
  int unsigned start_cnt;
  int          start_held;
  int          start_nogrant;

  initial begin
    repeat (3) @(negedge clk);
    #3;
    chk("rst_wren", 64'(usb_wren_l), 64'(1));
    chk("rst_oe", 64'(usb_data_oe), 64'(0));
    chk("rst_req", 64'(bus_req), 64'(0));
    chk("rst_ready", 64'(s_ready), 64'(0));
    chk("rst_data", 64'({usb_be_o, usb_data_o}), 64'(0));
    chk("rst_count", 64'(words_sent), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    single_word();

    // 150 back-to-back words split into capped bursts.
    idle(3);
    bursts_q.delete();
    start_cnt = model_cnt;
    send(150, 0, -1, 0);
    drain();
    #3;
    chk("burst_total", 64'(words_sent), 64'(start_cnt + 150));
    chk("burst_count", 64'(bursts_q.size()), 64'(3));
    exp_b = '{64, 64, 22};
    for (int i = 0; i < 3 && i < bursts_q.size(); i++)
      chk($sformatf("burst_len_%0d", i), 64'(bursts_q[i]), 64'(exp_b[i]));
    @(negedge clk);

    // Chip full for 5 cycles in the middle of a 10-word burst.
    start_cnt  = model_cnt;
    start_held = held_cycles;
    fork
      send(10, 1, -1, 0);
      begin
        for (int w = 0; w < 200 && model_cnt < start_cnt + 4; w++) @(negedge clk);
        #1 full_force = 1'b1;
        repeat (5) @(negedge clk);
        #1 full_force = 1'b0;
      end
    join
    drain();
    #3;
    chk("bp_total", 64'(words_sent), 64'(start_cnt + 10));
    chk("bp_held_cycles", 64'(held_cycles - start_held), 64'(5));
    @(negedge clk);

    // Stream starves after the third word.
    bursts_q.delete();
    start_cnt = model_cnt;
    send(8, 1, 2, 6);
    drain();
    #3;
    chk("starve_total", 64'(words_sent), 64'(start_cnt + 8));
    chk("starve_bursts", 64'(bursts_q.size()), 64'(2));
    if (bursts_q.size() == 2) begin
      chk("starve_burst0", 64'(bursts_q[0]), 64'(3));
      chk("starve_burst1", 64'(bursts_q[1]), 64'(5));
    end
    @(negedge clk);

    // Slow arbiter: grant 20 cycles after the request.
    gnt_tie   = 1'b0;
    gnt_fixed = 20;
    idle(3);
    start_nogrant = nogrant_cycles;
    start_cnt     = model_cnt;
    send(3, 1, -1, 0);
    drain();
    #3;
    chk("arb_wait", 64'(nogrant_cycles - start_nogrant >= 20), 64'(1));
    chk("arb_total", 64'(words_sent), 64'(start_cnt + 3));
    @(negedge clk);

    // Random traffic, backpressure and grant delays.
    gnt_fixed = -1;
    full_rand = 1'b1;
    start_cnt = model_cnt;
    send(200, 2, -1, 0);
    full_rand = 1'b0;
    drain();
    #3;
    chk("rand_total", 64'(words_sent), 64'(start_cnt + 200));
    @(negedge clk);

    // Reset while the second word of a burst sits in WRITE.
    gnt_tie = 1'b1;
    idle(3);
    s_valid = 1'b1;
    s_data  = 32'h1111_0001;
    s_be    = 4'hF;
    for (int w = 0; w < 10; w++) begin
      #3;
      if (s_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    s_data = 32'h2222_0002;
    #3;
    chk("rst_mid_ready_b", 64'(s_ready), 64'(1));
    @(negedge clk);
    s_valid = 1'b0;
    rst     = 1'b1;
    #3;
    chk("rst_mid_in_write", 64'(usb_wren_l), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_mid_wren", 64'(usb_wren_l), 64'(1));
    chk("rst_mid_oe", 64'(usb_data_oe), 64'(0));
    chk("rst_mid_req", 64'(bus_req), 64'(0));
    chk("rst_mid_count", 64'(words_sent), 64'(0));
    @(negedge clk);
    idle(2);
    single_word();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_fifo_tx.md
Name: usb_fifo_tx

Overview:
- FPGA-to-host transmitter for the FT601-style 245 synchronous USB FIFO. It is the write side of the interface whose read side drives usb_rden_l/usb_outen_l and samples usb_rx_empty.
- Takes 32-bit words plus byte enables from an internal valid/ready stream. Negotiates ownership of the shared usb_data/usb_be bus with the RX path through a req/gnt pair, inserts turnaround cycles, and bursts words to the chip with usb_wren_l, honouring usb_tx_full.
- Tristate buffers stay in the top level; this block only produces the output enable.

Parameters:
- WIDTH, 32, data bus width.
- MAX_BURST, 64, maximum words accepted per bus ownership; must be >= 1.
- COUNT_W, 32, width of the words_sent statistics counter.

Ports:
- clk  in  1  system clock (USB FIFO clock domain)
- rst  in  1  synchronous, active-high reset
- s_data  in  WIDTH  word to transmit
- s_be  in  4  byte enables for s_data
- s_valid  in  1  word available; must stay high with data stable until s_ready
- s_ready  out  1  word consumed on the rising edge where s_valid && s_ready
- bus_req  out  1  request ownership of usb_data/usb_be
- bus_gnt  in  1  ownership granted; arbiter must not revoke while bus_req=1
- usb_tx_full  in  1  0 = chip can accept a word; 1 = full
- usb_wren_l  out  1  active-low write strobe
- usb_data_o  out  WIDTH  data to bus
- usb_be_o  out  4  byte enables to bus
- usb_data_oe  out  1  drive enable for usb_data/usb_be tristates
- words_sent  out  COUNT_W  running count of words accepted by the chip; wraps

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; usb_wren_l=1; usb_data_oe=0; usb_data_o=0; usb_be_o=0; bus_req=0; s_ready=0; burst_cnt=0; words_sent=0.
  - Reset overrides all other inputs in that cycle.
- Registered outputs: usb_wren_l, usb_data_oe, usb_data_o, usb_be_o, bus_req. s_ready is combinational from state, usb_tx_full and burst_cnt.
- Acceptance rule: a word is taken by the chip on a rising edge where usb_wren_l=0 and usb_tx_full=0. Only accepted words increment words_sent.
- IDLE: bus_req=0, oe=0, wren_l=1. s_valid=1 -> REQ.
- REQ: bus_req=1, oe=0. bus_gnt=1 -> TURN. Wait indefinitely otherwise.
- TURN (one cycle):
  - Outputs: oe=1, wren_l=1, s_ready=1.
  - Transition: s_data/s_be load into the output registers, burst_cnt<=0 -> WRITE.
- WRITE: oe=1, wren_l=0, output registers hold the current word.
  - usb_tx_full=1: hold the word, wren_l stays 0, s_ready=0, no count change.
  - usb_tx_full=0 (word accepted): words_sent+1 and burst_cnt+1.
    - If s_valid=1 and burst_cnt < MAX_BURST-1: s_ready=1, next word loaded, stay in WRITE (back-to-back, one word per clock).
    - Otherwise: s_ready=0 and go to RELEASE with wren_l<=1.
- RELEASE (one cycle):
  - Outputs: wren_l=1, oe=0, bus_req=1.
  - Transition: -> IDLE, where bus_req<=0. The bus is undriven for at least one cycle before the RX side may drive it.
- Latency: s_valid rises before edge 0 with gnt tied high -> REQ in cycle 1, TURN in cycle 2, first wren_l=0 in cycle 3. First acceptance is at edge 3 if tx_full=0.
- s_valid dropping after an accept ends the burst (RELEASE). New data restarts from IDLE. No word is lost or duplicated.
- MAX_BURST=1: every word goes through REQ/TURN/WRITE/RELEASE.
- Reset mid-WRITE: the next cycle has wren_l=1 and oe=0. The word in the output register is discarded and not counted; it was already consumed from the stream.
- bus_gnt is only sampled in REQ. Deassertion while bus_req=1 is a protocol violation, flagged by a bench assertion, and the RTL ignores it.
- usb_data_oe=1 and usb_wren_l=0 never occur outside TURN/WRITE. usb_wren_l=0 implies usb_data_oe=1.

Test Plan:
- Single word: s_data=0xDEADBEEF, s_be=0xF, gnt tied 1, tx_full=0 -> wren_l low for exactly 1 cycle (cycle 3) with bus=0xDEADBEEF. words_sent=1. oe high in cycles 2-3 only; bus_req high in cycles 1-4.
- Burst cap: 150 consecutive words 0..149, MAX_BURST=64, tx_full=0 -> three bursts of 64, 64 and 22 words, each separated by RELEASE/IDLE/REQ/TURN. Data arrives in order with no gaps inside a burst. words_sent=150.
- Backpressure: tx_full=1 for 5 cycles in the middle of a 10-word burst -> the held word stays on the bus with wren_l=0 and is counted once. words_sent=10, with no duplicates at the monitor.
- Arbitration: gnt held 0 for 20 cycles after bus_req -> oe=0 and wren_l=1 throughout. Writing begins 2 cycles after gnt rises. Assertion: gnt never drops while bus_req=1.
- Stream starvation: s_valid drops after word 3 of 8 -> RELEASE after the third acceptance, a new REQ when s_valid returns, and all 8 words delivered in order.
- Reset mid-burst: rst=1 during WRITE -> next cycle wren_l=1, oe=0, bus_req=0, words_sent=0. Post-reset single-word transfer is correct.
